wqe_ptr_table: RTL and testbench
================================

WQE_PTR_TABLE -- requirements
Module: wqe_ptr_table

Interface
REQ-001 SHALL have parameter WQE_INDEX_WIDTH, 10, WQE index width; table depth = 2**WQE_INDEX_WIDTH.
REQ-002 SHALL have parameter WQE_SOURCE_LENGTH, 11, source-buffer pointer width.
REQ-003 SHALL have port sys_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port sys_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port s_axis_Pallocate_valid  input  1  allocation result valid from pointer allocator.
REQ-006 SHALL have port s_axis_Pallocate_id  input  WQE_INDEX_WIDTH  WQE index owning the pointer.
REQ-007 SHALL have port s_axis_Pallocate_ptr  input  WQE_SOURCE_LENGTH  allocated buffer pointer.
REQ-008 SHALL have port s_axis_Pallocate_ready  output  1  allocation accepted.
REQ-009 SHALL have port s_axis_Cmpl_valid  input  1  WQE completion request.
REQ-010 SHALL have port s_axis_Cmpl_id  input  WQE_INDEX_WIDTH  completed WQE index.
REQ-011 SHALL have port s_axis_Cmpl_ready  output  1  completion accepted.
REQ-012 SHALL have port m_axis_Brelease_valid  output  1  pointer release to allocator.
REQ-013 SHALL have port m_axis_Brelease_ptr  output  WQE_SOURCE_LENGTH  pointer being released.
REQ-014 SHALL have port m_axis_Brelease_ready  input  1  allocator accepts release.
REQ-015 SHALL have port s_axis_Lookup_valid  input  1  pointer lookup request.
REQ-016 SHALL have port s_axis_Lookup_id  input  WQE_INDEX_WIDTH  WQE index to look up.
REQ-017 SHALL have port s_axis_Lookup_ready  output  1  lookup accepted.
REQ-018 SHALL have port m_axis_Lookup_valid  output  1  lookup response valid.
REQ-019 SHALL have port m_axis_Lookup_ptr  output  WQE_SOURCE_LENGTH  stored pointer (0 on miss).
REQ-020 SHALL have port m_axis_Lookup_hit  output  1  entry valid at lookup time.
REQ-021 SHALL have port m_axis_Lookup_ready  input  1  consumer accepts response.
REQ-022 SHALL have ports err_double_alloc, err_bad_release  output  1 each  single-cycle error pulses.
REQ-023 SHALL have ports err_cnt_double_alloc, err_cnt_bad_release  output  16 each  error counters.

Function
REQ-024 SHALL hold per index a pointer (RAM) and a valid bit (flop vector); one table operation per cycle.
REQ-025 SHALL run FSM IDLE, REL, LKP; only IDLE accepts requests; priority Cmpl > Pallocate > Lookup.
REQ-026 SHALL drive each s_axis_*_ready combinationally high in IDLE only when no higher-priority valid is asserted.
REQ-027 Pallocate handshake: SHALL write ptr, set valid, stay IDLE; if already valid, overwrite and pulse err_double_alloc next cycle.
REQ-028 Cmpl handshake on valid entry: SHALL enter REL, assert m_axis_Brelease_valid with stored ptr exactly 1 cycle later, clear valid bit on that cycle.
REQ-029 SHALL hold Brelease valid/ptr stable until m_axis_Brelease_ready; return to IDLE the cycle after handshake.
REQ-030 Cmpl on invalid entry: SHALL not assert Brelease, pulse err_bad_release 1 cycle later, remain IDLE.
REQ-031 Lookup handshake: SHALL enter LKP, present ptr/hit 1 cycle later, hold until m_axis_Lookup_ready, then IDLE; lookup SHALL NOT modify state.
REQ-032 Index arithmetic SHALL use full WQE_INDEX_WIDTH, no wrap or aliasing; index 2**WQE_INDEX_WIDTH-1 valid.
REQ-033 Back-to-back: Pallocate SHALL be accepted every IDLE cycle; Cmpl/Lookup throughput SHALL be one per 2 cycles minimum.
REQ-034 Allocate then lookup of same id in next cycle SHALL return the new ptr with hit=1.

Reset
REQ-035 SHALL, on sys_rst high at a clock edge, clear all valid bits, go IDLE, drive every output 0 (counters 0); RAM contents need not reset.
REQ-036 Reset mid REL/LKP SHALL drop the pending response; the dropped release SHALL NOT be reissued.

Configuration
REQ-037 With WQE_PTR_ERR_CNT_EN defined, err_cnt_* SHALL count respective error pulses, saturating at 16'hFFFF.
REQ-038 Without WQE_PTR_ERR_CNT_EN, err_cnt_* SHALL be tied 0 and counter logic absent; error pulses unaffected.

Structure
REQ-039 SHALL place width defaults, FSM state enum and counter width in shared package wqe_pkg.
REQ-040 SHALL instantiate one sub-module wqe_ptr_ram (1 write, 1 registered read port, depth 2**WQE_INDEX_WIDTH).

Verification
REQ-041 Alloc id=5 ptr=0x123; Cmpl id=5 -> Brelease_ptr=0x123 one cycle later; Lookup id=5 -> hit=0, ptr=0.
REQ-042 Cmpl id=7 never allocated -> no Brelease, err_bad_release pulse, err_cnt_bad_release=1 (macro on).
REQ-043 Alloc id=1023 ptr=0x7FF twice -> err_double_alloc once; Lookup id=1023 -> ptr=0x7FF, hit=1.
REQ-044 Cmpl and Pallocate valid same cycle in IDLE -> Cmpl accepted, Pallocate_ready=0 until FSM back in IDLE.
REQ-045 Brelease_ready held 0 for 10 cycles -> valid/ptr stable; sys_rst in REL -> Brelease_valid=0 next cycle, no reissue.

Source files
------------

// File: rtl/wqe_pkg.sv
// Shared widths, counter width and FSM encoding for the WQE pointer table.
package wqe_pkg;
  localparam int WQE_INDEX_WIDTH_DEF   = 10;
  localparam int WQE_SOURCE_LENGTH_DEF = 11;
  localparam int ERR_CNT_W             = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REL  = 2'd1,
    ST_LKP  = 2'd2
  } state_t;
endpackage

// File: rtl/wqe_ptr_ram.sv
// Pointer store: one write port, one registered read port (data 1 cycle after re).
// No reset on contents or read data; the table gates the read data with its own state.
module wqe_ptr_ram
  import wqe_pkg::*;
#(
  parameter int AW = WQE_INDEX_WIDTH_DEF,
  parameter int DW = WQE_SOURCE_LENGTH_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/wqe_ptr_table.sv
// WQE index -> source-buffer pointer table; release/lookup answer 1 cycle after accept, held until ready.
// Requests accepted only in IDLE (Cmpl > Pallocate > Lookup). WQE_PTR_ERR_CNT_EN enables saturating error counters.
module wqe_ptr_table
  import wqe_pkg::*;
#(
  parameter int WQE_INDEX_WIDTH   = WQE_INDEX_WIDTH_DEF,
  parameter int WQE_SOURCE_LENGTH = WQE_SOURCE_LENGTH_DEF
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         s_axis_Pallocate_valid,
  input  logic [WQE_INDEX_WIDTH-1:0]   s_axis_Pallocate_id,
  input  logic [WQE_SOURCE_LENGTH-1:0] s_axis_Pallocate_ptr,
  output logic                         s_axis_Pallocate_ready,
  input  logic                         s_axis_Cmpl_valid,
  input  logic [WQE_INDEX_WIDTH-1:0]   s_axis_Cmpl_id,
  output logic                         s_axis_Cmpl_ready,
  output logic                         m_axis_Brelease_valid,
  output logic [WQE_SOURCE_LENGTH-1:0] m_axis_Brelease_ptr,
  input  logic                         m_axis_Brelease_ready,
  input  logic                         s_axis_Lookup_valid,
  input  logic [WQE_INDEX_WIDTH-1:0]   s_axis_Lookup_id,
  output logic                         s_axis_Lookup_ready,
  output logic                         m_axis_Lookup_valid,
  output logic [WQE_SOURCE_LENGTH-1:0] m_axis_Lookup_ptr,
  output logic                         m_axis_Lookup_hit,
  input  logic                         m_axis_Lookup_ready,
  output logic                         err_double_alloc,
  output logic                         err_bad_release,
  output logic [ERR_CNT_W-1:0]         err_cnt_double_alloc,
  output logic [ERR_CNT_W-1:0]         err_cnt_bad_release
);
  localparam int DEPTH = 2**WQE_INDEX_WIDTH;

  state_t                       state, state_nxt;
  logic [DEPTH-1:0]             entry_vld;
  logic                         idle, hit_q;
  logic                         alloc_fire, cmpl_fire, lkp_fire;
  logic                         ram_re;
  logic [WQE_INDEX_WIDTH-1:0]   ram_raddr;
  logic [WQE_SOURCE_LENGTH-1:0] rd_ptr;

  // Readies are held low while reset is asserted so every output reads 0.
  assign idle                   = (state == ST_IDLE) && !sys_rst;
  assign s_axis_Cmpl_ready      = idle;
  assign s_axis_Pallocate_ready = idle && !s_axis_Cmpl_valid;
  assign s_axis_Lookup_ready    = idle && !s_axis_Cmpl_valid && !s_axis_Pallocate_valid;

  assign cmpl_fire  = s_axis_Cmpl_valid && s_axis_Cmpl_ready;
  assign alloc_fire = s_axis_Pallocate_valid && s_axis_Pallocate_ready;
  assign lkp_fire   = s_axis_Lookup_valid && s_axis_Lookup_ready;

  assign ram_re    = cmpl_fire || lkp_fire;
  assign ram_raddr = cmpl_fire ? s_axis_Cmpl_id : s_axis_Lookup_id;

  wqe_ptr_ram #(
    .AW (WQE_INDEX_WIDTH),
    .DW (WQE_SOURCE_LENGTH)
  ) u_ram (
    .clk   (sys_clk),
    .we    (alloc_fire),
    .waddr (s_axis_Pallocate_id),
    .wdata (s_axis_Pallocate_ptr),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (rd_ptr)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmpl_fire && entry_vld[s_axis_Cmpl_id]) state_nxt = ST_REL;
        else if (lkp_fire)                          state_nxt = ST_LKP;
      end
      ST_REL:  if (m_axis_Brelease_ready) state_nxt = ST_IDLE;
      ST_LKP:  if (m_axis_Lookup_ready)   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    m_axis_Brelease_valid = 1'b0;
    m_axis_Brelease_ptr   = '0;
    m_axis_Lookup_valid   = 1'b0;
    m_axis_Lookup_hit     = 1'b0;
    m_axis_Lookup_ptr     = '0;
    case (state)
      ST_REL: begin
        m_axis_Brelease_valid = 1'b1;
        m_axis_Brelease_ptr   = rd_ptr;
      end
      ST_LKP: begin
        m_axis_Lookup_valid = 1'b1;
        m_axis_Lookup_hit   = hit_q;
        m_axis_Lookup_ptr   = hit_q ? rd_ptr : '0;
      end
      default: ;
    endcase
  end

  // Valid bit drops at accept, so a release killed by reset is never replayed.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      entry_vld        <= '0;
      hit_q            <= 1'b0;
      err_double_alloc <= 1'b0;
      err_bad_release  <= 1'b0;
    end else begin
      if (alloc_fire) entry_vld[s_axis_Pallocate_id] <= 1'b1;
      if (cmpl_fire)  entry_vld[s_axis_Cmpl_id]      <= 1'b0;
      if (lkp_fire)   hit_q <= entry_vld[s_axis_Lookup_id];
      err_double_alloc <= alloc_fire && entry_vld[s_axis_Pallocate_id];
      err_bad_release  <= cmpl_fire && !entry_vld[s_axis_Cmpl_id];
    end
  end

`ifdef WQE_PTR_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] cnt_da, cnt_br;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_da <= '0;
      cnt_br <= '0;
    end else begin
      if (err_double_alloc && (cnt_da != '1)) cnt_da <= cnt_da + ERR_CNT_W'(1);
      if (err_bad_release && (cnt_br != '1))  cnt_br <= cnt_br + ERR_CNT_W'(1);
    end
  end

  assign err_cnt_double_alloc = cnt_da;
  assign err_cnt_bad_release  = cnt_br;
`else
  assign err_cnt_double_alloc = '0;
  assign err_cnt_bad_release  = '0;
`endif
endmodule

// File: tb/tb_wqe_ptr_table.sv
// Directed self-checking bench for wqe_ptr_table; inputs change and outputs are sampled 1ns after the rising edge.
module tb_wqe_ptr_table;
  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        s_axis_Pallocate_valid;
  logic [9:0]  s_axis_Pallocate_id;
  logic [10:0] s_axis_Pallocate_ptr;
  logic        s_axis_Pallocate_ready;
  logic        s_axis_Cmpl_valid;
  logic [9:0]  s_axis_Cmpl_id;
  logic        s_axis_Cmpl_ready;
  logic        m_axis_Brelease_valid;
  logic [10:0] m_axis_Brelease_ptr;
  logic        m_axis_Brelease_ready;
  logic        s_axis_Lookup_valid;
  logic [9:0]  s_axis_Lookup_id;
  logic        s_axis_Lookup_ready;
  logic        m_axis_Lookup_valid;
  logic [10:0] m_axis_Lookup_ptr;
  logic        m_axis_Lookup_hit;
  logic        m_axis_Lookup_ready;
  logic        err_double_alloc;
  logic        err_bad_release;
  logic [15:0] err_cnt_double_alloc;
  logic [15:0] err_cnt_bad_release;

  int tests  = 0;
  int failed = 0;

`ifdef WQE_PTR_ERR_CNT_EN
  localparam logic [15:0] EXP_CNT = 16'd1;
`else
  localparam logic [15:0] EXP_CNT = 16'd0;
`endif

  always #5 sys_clk = ~sys_clk;

  wqe_ptr_table dut (
    .sys_clk                (sys_clk),
    .sys_rst                (sys_rst),
    .s_axis_Pallocate_valid (s_axis_Pallocate_valid),
    .s_axis_Pallocate_id    (s_axis_Pallocate_id),
    .s_axis_Pallocate_ptr   (s_axis_Pallocate_ptr),
    .s_axis_Pallocate_ready (s_axis_Pallocate_ready),
    .s_axis_Cmpl_valid      (s_axis_Cmpl_valid),
    .s_axis_Cmpl_id         (s_axis_Cmpl_id),
    .s_axis_Cmpl_ready      (s_axis_Cmpl_ready),
    .m_axis_Brelease_valid  (m_axis_Brelease_valid),
    .m_axis_Brelease_ptr    (m_axis_Brelease_ptr),
    .m_axis_Brelease_ready  (m_axis_Brelease_ready),
    .s_axis_Lookup_valid    (s_axis_Lookup_valid),
    .s_axis_Lookup_id       (s_axis_Lookup_id),
    .s_axis_Lookup_ready    (s_axis_Lookup_ready),
    .m_axis_Lookup_valid    (m_axis_Lookup_valid),
    .m_axis_Lookup_ptr      (m_axis_Lookup_ptr),
    .m_axis_Lookup_hit      (m_axis_Lookup_hit),
    .m_axis_Lookup_ready    (m_axis_Lookup_ready),
    .err_double_alloc       (err_double_alloc),
    .err_bad_release        (err_bad_release),
    .err_cnt_double_alloc   (err_cnt_double_alloc),
    .err_cnt_bad_release    (err_cnt_bad_release)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Single-cycle allocation issued from IDLE; no checking here.
  task automatic do_alloc(input logic [9:0] id, input logic [10:0] ptr);
    s_axis_Pallocate_valid = 1'b1;
    s_axis_Pallocate_id    = id;
    s_axis_Pallocate_ptr   = ptr;
    tick();
    s_axis_Pallocate_valid = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) tick();
    tests++; if ({s_axis_Pallocate_ready, s_axis_Cmpl_ready, s_axis_Lookup_ready} !== 3'b000) begin failed++; $display("FAIL rst_readies: got %b exp 000", {s_axis_Pallocate_ready, s_axis_Cmpl_ready, s_axis_Lookup_ready}); end
    tests++; if ({m_axis_Brelease_valid, m_axis_Lookup_valid, m_axis_Lookup_hit, err_double_alloc, err_bad_release} !== 5'b0) begin failed++; $display("FAIL rst_flags: got %b exp 00000", {m_axis_Brelease_valid, m_axis_Lookup_valid, m_axis_Lookup_hit, err_double_alloc, err_bad_release}); end
    tests++; if ({m_axis_Brelease_ptr, m_axis_Lookup_ptr} !== 22'h0) begin failed++; $display("FAIL rst_ptrs: got %h exp 0", {m_axis_Brelease_ptr, m_axis_Lookup_ptr}); end
    tests++; if ({err_cnt_double_alloc, err_cnt_bad_release} !== 32'h0) begin failed++; $display("FAIL rst_cnts: got %h exp 0", {err_cnt_double_alloc, err_cnt_bad_release}); end
    sys_rst = 1'b0;
    #1;
    tests++; if ({s_axis_Pallocate_ready, s_axis_Cmpl_ready, s_axis_Lookup_ready} !== 3'b111) begin failed++; $display("FAIL idle_readies: got %b exp 111", {s_axis_Pallocate_ready, s_axis_Cmpl_ready, s_axis_Lookup_ready}); end
  endtask

  task automatic test_alloc_release_lookup();
    s_axis_Pallocate_valid = 1'b1; s_axis_Pallocate_id = 10'd5; s_axis_Pallocate_ptr = 11'h123;
    #1;
    tests++; if (s_axis_Pallocate_ready !== 1'b1) begin failed++; $display("FAIL alloc_ready: got %b exp 1", s_axis_Pallocate_ready); end
    tick();
    s_axis_Pallocate_valid = 1'b0;
    tests++; if (err_double_alloc !== 1'b0) begin failed++; $display("FAIL first_alloc_err: got %b exp 0", err_double_alloc); end
    s_axis_Cmpl_valid = 1'b1; s_axis_Cmpl_id = 10'd5;
    tick();
    s_axis_Cmpl_valid = 1'b0;
    tests++; if (m_axis_Brelease_valid !== 1'b1) begin failed++; $display("FAIL rel_valid: got %b exp 1", m_axis_Brelease_valid); end
    tests++; if (m_axis_Brelease_ptr !== 11'h123) begin failed++; $display("FAIL rel_ptr: got %h exp 123", m_axis_Brelease_ptr); end
    tests++; if (s_axis_Cmpl_ready !== 1'b0) begin failed++; $display("FAIL rel_busy: got %b exp 0", s_axis_Cmpl_ready); end
    m_axis_Brelease_ready = 1'b1;
    tick();
    m_axis_Brelease_ready = 1'b0;
    tests++; if (m_axis_Brelease_valid !== 1'b0) begin failed++; $display("FAIL rel_done: got %b exp 0", m_axis_Brelease_valid); end
    s_axis_Lookup_valid = 1'b1; s_axis_Lookup_id = 10'd5;
    tick();
    s_axis_Lookup_valid = 1'b0;
    tests++; if ({m_axis_Lookup_valid, m_axis_Lookup_hit, m_axis_Lookup_ptr} !== {1'b1, 1'b0, 11'h0}) begin failed++; $display("FAIL lkp_freed: got v%b h%b p%h exp v1 h0 p0", m_axis_Lookup_valid, m_axis_Lookup_hit, m_axis_Lookup_ptr); end
    m_axis_Lookup_ready = 1'b1;
    tick();
    m_axis_Lookup_ready = 1'b0;
    tests++; if (m_axis_Lookup_valid !== 1'b0) begin failed++; $display("FAIL lkp_done: got %b exp 0", m_axis_Lookup_valid); end
  endtask

  task automatic test_bad_release();
    s_axis_Cmpl_valid = 1'b1; s_axis_Cmpl_id = 10'd7;
    tick();
    s_axis_Cmpl_valid = 1'b0;
    tests++; if (m_axis_Brelease_valid !== 1'b0) begin failed++; $display("FAIL bad_rel_valid: got %b exp 0", m_axis_Brelease_valid); end
    tests++; if (err_bad_release !== 1'b1) begin failed++; $display("FAIL bad_rel_pulse: got %b exp 1", err_bad_release); end
    tests++; if (s_axis_Cmpl_ready !== 1'b1) begin failed++; $display("FAIL bad_rel_idle: got %b exp 1", s_axis_Cmpl_ready); end
    tick();
    tests++; if (err_bad_release !== 1'b0) begin failed++; $display("FAIL bad_rel_pulse_end: got %b exp 0", err_bad_release); end
    tests++; if (err_cnt_bad_release !== EXP_CNT) begin failed++; $display("FAIL bad_rel_cnt: got %0d exp %0d", err_cnt_bad_release, EXP_CNT); end
    tests++; if (err_cnt_double_alloc !== 16'd0) begin failed++; $display("FAIL da_cnt_zero: got %0d exp 0", err_cnt_double_alloc); end
  endtask

  task automatic test_double_alloc();
    s_axis_Pallocate_valid = 1'b1; s_axis_Pallocate_id = 10'd1023; s_axis_Pallocate_ptr = 11'h7FF;
    tick();
    tests++; if ({s_axis_Pallocate_ready, err_double_alloc} !== 2'b10) begin failed++; $display("FAIL da_first: got rdy%b err%b exp rdy1 err0", s_axis_Pallocate_ready, err_double_alloc); end
    tick();
    s_axis_Pallocate_valid = 1'b0;
    s_axis_Lookup_valid = 1'b1; s_axis_Lookup_id = 10'd1023;
    tests++; if (err_double_alloc !== 1'b1) begin failed++; $display("FAIL da_pulse: got %b exp 1", err_double_alloc); end
    tick();
    s_axis_Lookup_valid = 1'b0;
    tests++; if (err_double_alloc !== 1'b0) begin failed++; $display("FAIL da_once: got %b exp 0", err_double_alloc); end
    tests++; if (err_cnt_double_alloc !== EXP_CNT) begin failed++; $display("FAIL da_cnt: got %0d exp %0d", err_cnt_double_alloc, EXP_CNT); end
    tests++; if ({m_axis_Lookup_valid, m_axis_Lookup_hit, m_axis_Lookup_ptr} !== {1'b1, 1'b1, 11'h7FF}) begin failed++; $display("FAIL lkp_top: got v%b h%b p%h exp v1 h1 p7ff", m_axis_Lookup_valid, m_axis_Lookup_hit, m_axis_Lookup_ptr); end
    tick();
    tests++; if ({m_axis_Lookup_valid, m_axis_Lookup_ptr} !== {1'b1, 11'h7FF}) begin failed++; $display("FAIL lkp_hold: got v%b p%h exp v1 p7ff", m_axis_Lookup_valid, m_axis_Lookup_ptr); end
    m_axis_Lookup_ready = 1'b1;
    tick();
    m_axis_Lookup_ready = 1'b0;
    tests++; if (m_axis_Lookup_valid !== 1'b0) begin failed++; $display("FAIL lkp_top_done: got %b exp 0", m_axis_Lookup_valid); end
  endtask

  task automatic test_priority();
    do_alloc(10'd9, 11'h0AA);
    s_axis_Cmpl_valid = 1'b1; s_axis_Cmpl_id = 10'd9;
    s_axis_Pallocate_valid = 1'b1; s_axis_Pallocate_id = 10'd10; s_axis_Pallocate_ptr = 11'h0BB;
    s_axis_Lookup_valid = 1'b1; s_axis_Lookup_id = 10'd9;
    #1;
    tests++; if ({s_axis_Cmpl_ready, s_axis_Pallocate_ready, s_axis_Lookup_ready} !== 3'b100) begin failed++; $display("FAIL prio_all: got %b exp 100", {s_axis_Cmpl_ready, s_axis_Pallocate_ready, s_axis_Lookup_ready}); end
    tick();
    s_axis_Cmpl_valid = 1'b0;
    s_axis_Lookup_valid = 1'b0;
    tests++; if (s_axis_Pallocate_ready !== 1'b0) begin failed++; $display("FAIL prio_rel_block: got %b exp 0", s_axis_Pallocate_ready); end
    tests++; if ({m_axis_Brelease_valid, m_axis_Brelease_ptr} !== {1'b1, 11'h0AA}) begin failed++; $display("FAIL prio_rel: got v%b p%h exp v1 p0aa", m_axis_Brelease_valid, m_axis_Brelease_ptr); end
    m_axis_Brelease_ready = 1'b1;
    tick();
    m_axis_Brelease_ready = 1'b0;
    s_axis_Lookup_valid = 1'b1; s_axis_Lookup_id = 10'd10;
    #1;
    tests++; if ({s_axis_Pallocate_ready, s_axis_Lookup_ready} !== 2'b10) begin failed++; $display("FAIL prio_alloc_over_lkp: got %b exp 10", {s_axis_Pallocate_ready, s_axis_Lookup_ready}); end
    tick();
    s_axis_Pallocate_valid = 1'b0;
    tick();
    s_axis_Lookup_valid = 1'b0;
    tests++; if ({m_axis_Lookup_hit, m_axis_Lookup_ptr} !== {1'b1, 11'h0BB}) begin failed++; $display("FAIL prio_late_alloc: got h%b p%h exp h1 p0bb", m_axis_Lookup_hit, m_axis_Lookup_ptr); end
    m_axis_Lookup_ready = 1'b1;
    tick();
    m_axis_Lookup_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    s_axis_Pallocate_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_axis_Pallocate_id = 10'(i); s_axis_Pallocate_ptr = 11'h030 + 11'(i);
      #1;
      tests++; if (s_axis_Pallocate_ready !== 1'b1) begin failed++; $display("FAIL b2b_alloc_rdy%0d: got %b exp 1", i, s_axis_Pallocate_ready); end
      tick();
    end
    s_axis_Pallocate_valid = 1'b0;
    s_axis_Lookup_valid = 1'b1; s_axis_Lookup_id = 10'd3;
    tick();
    s_axis_Lookup_valid = 1'b0;
    tests++; if ({m_axis_Lookup_hit, m_axis_Lookup_ptr} !== {1'b1, 11'h033}) begin failed++; $display("FAIL alloc_then_lkp: got h%b p%h exp h1 p033", m_axis_Lookup_hit, m_axis_Lookup_ptr); end
    m_axis_Lookup_ready = 1'b1;
    tick();
    m_axis_Lookup_ready = 1'b0;
    m_axis_Brelease_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_axis_Cmpl_valid = 1'b1; s_axis_Cmpl_id = 10'(i);
      #1;
      tests++; if (s_axis_Cmpl_ready !== 1'b1) begin failed++; $display("FAIL b2b_cmpl_rdy%0d: got %b exp 1", i, s_axis_Cmpl_ready); end
      tick();
      s_axis_Cmpl_valid = 1'b0;
      tests++; if ({m_axis_Brelease_valid, m_axis_Brelease_ptr} !== {1'b1, 11'h030 + 11'(i)}) begin failed++; $display("FAIL b2b_rel%0d: got v%b p%h exp v1 p%h", i, m_axis_Brelease_valid, m_axis_Brelease_ptr, 11'h030 + 11'(i)); end
      tick();
    end
    m_axis_Brelease_ready = 1'b0;
    s_axis_Lookup_valid = 1'b1; s_axis_Lookup_id = 10'd0;
    tick();
    s_axis_Lookup_valid = 1'b0;
    tests++; if ({m_axis_Lookup_hit, m_axis_Lookup_ptr} !== {1'b0, 11'h0}) begin failed++; $display("FAIL lkp_id0_freed: got h%b p%h exp h0 p0", m_axis_Lookup_hit, m_axis_Lookup_ptr); end
    m_axis_Lookup_ready = 1'b1;
    tick();
    m_axis_Lookup_ready = 1'b0;
  endtask

  task automatic test_hold_and_reset();
    do_alloc(10'd20, 11'h2AB);
    s_axis_Cmpl_valid = 1'b1; s_axis_Cmpl_id = 10'd20;
    tick();
    s_axis_Cmpl_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tests++; if ({m_axis_Brelease_valid, m_axis_Brelease_ptr} !== {1'b1, 11'h2AB}) begin failed++; $display("FAIL rel_stable%0d: got v%b p%h exp v1 p2ab", i, m_axis_Brelease_valid, m_axis_Brelease_ptr); end
      tick();
    end
    sys_rst = 1'b1;
    tick();
    tests++; if ({m_axis_Brelease_valid, m_axis_Brelease_ptr} !== {1'b0, 11'h0}) begin failed++; $display("FAIL rel_rst_drop: got v%b p%h exp v0 p0", m_axis_Brelease_valid, m_axis_Brelease_ptr); end
    tests++; if ({err_cnt_double_alloc, err_cnt_bad_release} !== 32'h0) begin failed++; $display("FAIL rel_rst_cnts: got %h exp 0", {err_cnt_double_alloc, err_cnt_bad_release}); end
    sys_rst = 1'b0;
    m_axis_Brelease_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (m_axis_Brelease_valid !== 1'b0) begin failed++; $display("FAIL no_reissue%0d: got %b exp 0", i, m_axis_Brelease_valid); end
    end
    m_axis_Brelease_ready = 1'b0;
    tests++; if (s_axis_Cmpl_ready !== 1'b1) begin failed++; $display("FAIL post_rst_idle: got %b exp 1", s_axis_Cmpl_ready); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sys_rst = 1'b1;
    s_axis_Pallocate_valid = 1'b0; s_axis_Pallocate_id = '0; s_axis_Pallocate_ptr = '0;
    s_axis_Cmpl_valid = 1'b0; s_axis_Cmpl_id = '0;
    s_axis_Lookup_valid = 1'b0; s_axis_Lookup_id = '0;
    m_axis_Brelease_ready = 1'b0; m_axis_Lookup_ready = 1'b0;
    test_reset();
    test_alloc_release_lookup();
    test_bad_release();
    test_double_alloc();
    test_priority();
    test_back_to_back();
    test_hold_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
